// File: rtl/inv_key_schedule.sv
`default_nettype none
// ============================================================================
//  Module   : inv_key_schedule
//  Purpose  : Iterative AES-128 inverse key expander. Emits round keys from
//             NUM_ROUNDS down to 0, one per accepted output handshake.
//  Revision : 1.0 - initial release
// ============================================================================

module aes_sbox (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse in GF(2^8); zero maps to zero.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] res;
        sq  = a;
        res = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq  = gf_mul(sq, sq);
            res = gf_mul(res, sq);
        end
        return res;
    endfunction

    logic [7:0] w_inv;

    assign w_inv  = gf_inv(i_byte);
    assign o_byte = w_inv
                  ^ {w_inv[6:0], w_inv[7]}
                  ^ {w_inv[5:0], w_inv[7:6]}
                  ^ {w_inv[4:0], w_inv[7:5]}
                  ^ {w_inv[3:0], w_inv[7:4]}
                  ^ 8'h63;

endmodule

module inv_key_schedule #(
    parameter int NUM_ROUNDS = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         abort,
    input  logic [127:0] last_key,
    output logic [127:0] key_out,
    output logic [3:0]   key_idx,
    output logic         key_valid,
    input  logic         key_ready,
    output logic         busy,
    output logic         done
);

    localparam logic [3:0] c_last_idx = 4'(NUM_ROUNDS);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_OUT  = 1'b1
    } state_t;

    state_t         r_state;
    logic [127:0]   r_key;
    logic [3:0]     r_idx;
    logic           r_valid;
    logic           r_busy;
    logic           r_done;

    logic [31:0]    w_k0, w_k1, w_k2, w_k3;
    logic [31:0]    w_w0, w_w1, w_w2, w_w3;
    logic [31:0]    w_rot;
    logic [31:0]    w_sub;
    logic [3:0]     w_rnd;
    logic [7:0]     w_rcon;
    logic [127:0]   w_next;

    assign w_k0 = r_key[127:96];
    assign w_k1 = r_key[95:64];
    assign w_k2 = r_key[63:32];
    assign w_k3 = r_key[31:0];

    // Undo the forward XOR chain first; w3 is then the previous round's last word.
    assign w_w3  = w_k3 ^ w_k2;
    assign w_w2  = w_k2 ^ w_k1;
    assign w_w1  = w_k1 ^ w_k0;
    assign w_rot = {w_w3[23:0], w_w3[31:24]};

    generate
        for (genvar i = 0; i < 4; i++) begin : g_sbox
            aes_sbox u_sbox (
                .i_byte (w_rot[i*8 +: 8]),
                .o_byte (w_sub[i*8 +: 8])
            );
        end
    endgenerate

    assign w_rnd = r_idx - 4'd1;

    always_comb begin
        w_rcon = 8'h00;
        case (w_rnd)
            4'd0:    w_rcon = 8'h01;
            4'd1:    w_rcon = 8'h02;
            4'd2:    w_rcon = 8'h04;
            4'd3:    w_rcon = 8'h08;
            4'd4:    w_rcon = 8'h10;
            4'd5:    w_rcon = 8'h20;
            4'd6:    w_rcon = 8'h40;
            4'd7:    w_rcon = 8'h80;
            4'd8:    w_rcon = 8'h1b;
            4'd9:    w_rcon = 8'h36;
            default: w_rcon = 8'h00;
        endcase
    end

    assign w_w0   = w_k0 ^ w_sub ^ {w_rcon, 24'h000000};
    assign w_next = {w_w0, w_w1, w_w2, w_w3};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_key   <= '0;
            r_idx   <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (abort) begin
                r_state <= ST_IDLE;
                r_valid <= 1'b0;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (start) begin
                            r_key   <= last_key;
                            r_idx   <= c_last_idx;
                            r_state <= ST_OUT;
                            r_valid <= 1'b1;
                            r_busy  <= 1'b1;
                        end
                    end
                    ST_OUT: begin
                        if (key_ready) begin
                            if (r_idx == 4'd0) begin
                                r_state <= ST_IDLE;
                                r_valid <= 1'b0;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                            end else begin
                                r_key <= w_next;
                                r_idx <= r_idx - 4'd1;
                            end
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign key_out   = r_key;
    assign key_idx   = r_idx;
    assign key_valid = r_valid;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_inv_key_schedule.sv
`default_nettype none
// ============================================================================
//  Module   : tb_inv_key_schedule
//  Purpose  : Scoreboard bench for the AES-128 inverse key expander.
//  Revision : 1.0 - initial release
// ============================================================================

module tb_inv_key_schedule;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic         key_ready = 1'b0;
    logic [127:0] last_key = '0;
    logic [127:0] key_out;
    logic [3:0]   key_idx;
    logic         key_valid;
    logic         busy;
    logic         done;

    always #5 clk = ~clk;

    inv_key_schedule #(.NUM_ROUNDS(10)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .last_key  (last_key),
        .key_out   (key_out),
        .key_idx   (key_idx),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .busy      (busy),
        .done      (done)
    );

    typedef struct {
        logic [3:0]   idx;
        logic [127:0] key;
        bit           chk;
    } exp_t;

    exp_t         sb[$];
    int           n_tests = 0;
    int           n_fail  = 0;
    int           n_hs    = 0;
    int           n_done  = 0;
    bit           rand_ready = 0;
    logic [127:0] fips [0:10];
    logic [127:0] cap  [0:10];

    logic [2047:0] sbox_tab = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

    function automatic logic [7:0] sbx(input logic [7:0] x);
        return sbox_tab[2047 - 8*int'(x) -: 8];
    endfunction

    // Forward AES-128 key expansion: round r key -> round r+1 key.
    function automatic logic [127:0] fwd(input logic [127:0] k, input int r);
        logic [31:0] k0, k1, k2, k3, t, w0, w1, w2, w3;
        logic [7:0]  rc;
        logic [7:0]  rc_tab [0:9];
        rc_tab = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
        rc = rc_tab[r];
        {k0, k1, k2, k3} = k;
        t  = {sbx(k3[23:16]), sbx(k3[15:8]), sbx(k3[7:0]), sbx(k3[31:24])};
        w0 = k0 ^ t ^ {rc, 24'h0};
        w1 = k1 ^ w0;
        w2 = k2 ^ w1;
        w3 = k3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every accepted key, checks stalls and done.
    bit           exp_done = 0;
    bit           exp_restart = 0;
    bit           stalled = 0;
    logic [127:0] held_key;
    logic [3:0]   held_idx;

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            exp_done    = 0;
            exp_restart = 0;
            stalled     = 0;
        end else begin
            if (exp_done || done) check("done_pulse", done, exp_done);
            if (done) n_done++;
            if (exp_restart) begin
                check("restart_valid", key_valid, 1);
                check("restart_idx", key_idx, 10);
            end
            exp_restart = done && start && !abort;
            if (stalled) begin
                check("stall_valid", key_valid, 1);
                check("stall_key", key_out, held_key);
                check("stall_idx", key_idx, held_idx);
            end
            stalled  = key_valid && !key_ready && !abort;
            held_key = key_out;
            held_idx = key_idx;
            exp_done = 0;
            if (key_valid && key_ready && !abort) begin
                n_hs++;
                if (key_idx <= 4'd10) cap[key_idx] = key_out;
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_key: got idx %0d key %h expected no key", key_idx, key_out);
                end else begin
                    e = sb.pop_front();
                    check("key_idx", key_idx, e.idx);
                    if (e.chk) check("key_out", key_out, e.key);
                end
                if (key_idx == 4'd0) exp_done = 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        key_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    task automatic push_seq(input bit known, input logic [127:0] k);
        exp_t e;
        for (int r = 10; r >= 0; r--) begin
            e.idx = 4'(r);
            e.key = known ? fips[r] : k;
            e.chk = known || (r == 10);
            sb.push_back(e);
        end
    endtask

    task automatic wait_hs(input int target, input string name);
        for (int k = 0; k < 400 && n_hs < target; k++) tick();
        check({name, "_handshakes"}, n_hs, target);
    endtask

    task automatic run_seq(input bit known, input logic [127:0] key, input string name);
        int base_hs;
        int base_done;
        base_hs   = n_hs;
        base_done = n_done;
        last_key  = key;
        start     = 1'b1;
        push_seq(known, key);
        tick();
        start = 1'b0;
        wait_hs(base_hs + 11, name);
        tick();
        tick();
        check({name, "_done_count"}, n_done, base_done + 1);
        check({name, "_sb_empty"}, sb.size(), 0);
    endtask

    initial begin
        int base_done;
        logic [127:0] rk;

        fips[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        fips[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        fips[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        fips[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        fips[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        fips[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        fips[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        fips[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        fips[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        fips[9]  = 128'hac7766f319fadc2128d12941575c006e;
        fips[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

        repeat (2) @(posedge clk);
        #1;
        check("rst_key_out", key_out, 0);
        check("rst_key_idx", key_idx, 0);
        check("rst_key_valid", key_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst_n = 1'b1;
        tick();
        check("idle_valid", key_valid, 0);

        rand_ready = 0;
        run_seq(1, fips[10], "fips");

        rand_ready = 1;
        run_seq(1, fips[10], "backpressure");

        // Abort while key 5 is being accepted.
        rand_ready = 0;
        last_key   = fips[10];
        start      = 1'b1;
        push_seq(1, fips[10]);
        tick();
        start = 1'b0;
        for (int k = 0; k < 50 && !(key_valid && key_idx == 4'd5); k++) tick();
        check("abort_reached_idx5", key_idx, 5);
        abort     = 1'b1;
        key_ready = 1'b1;
        base_done = n_done;
        tick();
        abort = 1'b0;
        check("abort_valid", key_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_hold_idx", key_idx, 5);
        check("abort_hold_key", key_out, fips[5]);
        sb.delete();
        repeat (3) tick();
        check("abort_no_done", n_done, base_done);
        run_seq(1, fips[10], "after_abort");

        // Asynchronous reset between edges.
        rand_ready = 1;
        last_key   = fips[10];
        start      = 1'b1;
        push_seq(1, fips[10]);
        tick();
        start = 1'b0;
        wait_hs(n_hs + 4, "pre_reset");
        base_done = n_done;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_key_out", key_out, 0);
        check("async_rst_key_idx", key_idx, 0);
        check("async_rst_valid", key_valid, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_done", done, 0);
        sb.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        check("async_rst_no_done", n_done, base_done);
        run_seq(1, fips[10], "after_reset");

        // start held across two complete sequences.
        rand_ready = 0;
        base_done  = n_done;
        last_key   = fips[10];
        start      = 1'b1;
        push_seq(1, fips[10]);
        push_seq(1, fips[10]);
        wait_hs(n_hs + 22, "start_held");
        start = 1'b0;
        repeat (3) tick();
        check("start_held_done_count", n_done, base_done + 2);
        check("start_held_sb_empty", sb.size(), 0);

        // Random keys: forward expansion of each key must give the previous one.
        rand_ready = 1;
        for (int t = 0; t < 3; t++) begin
            rk = {$urandom, $urandom, $urandom, $urandom};
            run_seq(0, rk, "rand");
            for (int r = 0; r < 10; r++) begin
                check($sformatf("rand_fwd_r%0d", r), fwd(cap[r], r), cap[r+1]);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
